pc_redirect_ctrl: RTL and testbench

Sequencing controller for the program counter and IF/ID/ID/EX pipeline registers. It arbitrates between taken-branch redirects from EX and jump redirects from ID, and applies load-use and memory-wait stalls. It drives the PC's write enable, source select and redirect target, plus the flush and write enables of the front-end pipeline registers. When a redirect arrives while the pipeline is frozen, the block holds it and replays it once the freeze ends.

---
 rtl/pc_redirect_ctrl_pkg.sv | 19 +
 rtl/ctrl_event_counter.sv | 19 +
 rtl/pc_redirect_ctrl.sv | 119 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings for the PC redirect controller: PC source select, FSM states
// and held-redirect kinds.
package pc_redirect_ctrl_pkg;

  localparam logic [1:0] PC_SRC_NORMAL = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef enum logic {
    HOLD_BRANCH = 1'b0,
    HOLD_JUMP   = 1'b1
  } hold_kind_t;

endpackage

// File: rtl/ctrl_event_counter.sv
// Enable counter with synchronous active-high reset; wraps modulo 2^CNT_W.
// Only present in builds with PC_REDIRECT_STATS_EN defined.
`ifdef PC_REDIRECT_STATS_EN
module ctrl_event_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (Reset)   count <= '0;
    else if (en) count <= count + 1'b1;
  end

endmodule
`endif

// File: rtl/pc_redirect_ctrl.sv
// PC / front-end sequencing: branch/jump redirect arbitration, stalls, and
// replay of redirects that arrive during ext_stall. Stats via PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              hazard_stall,
  input  logic              ext_stall,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pending,
  output logic [CNT_W-1:0]  redirect_count,
  output logic [CNT_W-1:0]  stall_count
);

  state_t            state_q;
  hold_kind_t        hold_kind_q;
  logic [ADDR_W-1:0] hold_target_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= ST_RUN;
      hold_kind_q   <= HOLD_BRANCH;
      hold_target_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ext_stall && (branch_req || jump_req)) begin
            state_q       <= ST_HOLD;
            hold_kind_q   <= branch_req ? HOLD_BRANCH : HOLD_JUMP;
            hold_target_q <= branch_req ? branch_target : jump_target;
          end
        end
        ST_HOLD: begin
          if (!ext_stall) begin
            state_q <= ST_RUN;
          end else if (branch_req) begin
            hold_kind_q   <= HOLD_BRANCH;
            hold_target_q <= branch_target;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign pending = (state_q == ST_HOLD);

  // Mealy outputs; Reset forces the normal-RUN values.
  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    pc_src          = PC_SRC_NORMAL;
    redirect_target = '0;
    if (!Reset) begin
      if (ext_stall) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (state_q == ST_HOLD) begin
        ifid_flush      = 1'b1;
        redirect_target = hold_target_q;
        if (hold_kind_q == HOLD_BRANCH) begin
          pc_src     = PC_SRC_BRANCH;
          idex_flush = 1'b1;
        end else begin
          pc_src = PC_SRC_JUMP;
        end
      end else if (branch_req) begin
        pc_src          = PC_SRC_BRANCH;
        redirect_target = branch_target;
        ifid_flush      = 1'b1;
        idex_flush      = 1'b1;
      end else if (jump_req) begin
        pc_src          = PC_SRC_JUMP;
        redirect_target = jump_target;
        ifid_flush      = 1'b1;
      end else if (hazard_stall) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  // A non-normal pc_src marks exactly the redirect-issuing cycles.
  ctrl_event_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (pc_src != PC_SRC_NORMAL),
    .count (redirect_count)
  );

  ctrl_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (!pc_write),
    .count (stall_count)
  );
`else
  assign redirect_count = '0;
  assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; counter checks follow PC_REDIRECT_STATS_EN.
module tb_pc_redirect_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              hazard_stall, ext_stall, branch_req, jump_req;
  logic [ADDR_W-1:0] branch_target, jump_target;
  logic              pc_write, ifid_write, ifid_flush, idex_flush, pending;
  logic [1:0]        pc_src;
  logic [ADDR_W-1:0] redirect_target;
  logic [CNT_W-1:0]  redirect_count, stall_count;

  int total = 0;
  int bad   = 0;

  pc_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .hazard_stall    (hazard_stall),
    .ext_stall       (ext_stall),
    .branch_req      (branch_req),
    .branch_target   (branch_target),
    .jump_req        (jump_req),
    .jump_target     (jump_target),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .redirect_target (redirect_target),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pending         (pending),
    .redirect_count  (redirect_count),
    .stall_count     (stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; checks run 2 units later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // pc_write, ifid_write, ifid_flush, idex_flush, pc_src, redirect_target
  task automatic chk_out(input string tag, input logic pw, input logic iw,
                         input logic ifl, input logic idl, input logic [1:0] src,
                         input logic [31:0] tgt);
    chk({tag, ".pc_write"},   {31'b0, pc_write},   {31'b0, pw});
    chk({tag, ".ifid_write"}, {31'b0, ifid_write}, {31'b0, iw});
    chk({tag, ".ifid_flush"}, {31'b0, ifid_flush}, {31'b0, ifl});
    chk({tag, ".idex_flush"}, {31'b0, idex_flush}, {31'b0, idl});
    chk({tag, ".pc_src"},     {30'b0, pc_src},     {30'b0, src});
    chk({tag, ".target"},     redirect_target,     tgt);
  endtask

  task automatic chk_pend(input string tag, input logic p);
    chk({tag, ".pending"}, {31'b0, pending}, {31'b0, p});
  endtask

  task automatic chk_cnt(input string tag, input int unsigned red, input int unsigned stl);
`ifdef PC_REDIRECT_STATS_EN
    chk({tag, ".redirect_count"}, {28'b0, redirect_count}, red);
    chk({tag, ".stall_count"},    {28'b0, stall_count},    stl);
`else
    chk({tag, ".redirect_count"}, {28'b0, redirect_count}, 32'd0 & red);
    chk({tag, ".stall_count"},    {28'b0, stall_count},    32'd0 & stl);
`endif
  endtask

  task automatic idle_inputs();
    hazard_stall = 1'b0; ext_stall = 1'b0;
    branch_req = 1'b0; jump_req = 1'b0;
    branch_target = '0; jump_target = '0;
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    branch_req = 1'b1; branch_target = 32'h40;
    #1;
    tick();
    settle();
    chk_out("reset", 1, 1, 0, 0, 2'b00, 32'h0);
    chk_pend("reset", 0);
    tick();

    idle_inputs();
    Reset = 1'b0;
    settle();
    chk_cnt("post_reset", 0, 0);
    chk_out("normal", 1, 1, 0, 0, 2'b00, 32'h0);
    chk_pend("normal", 0);
    tick();

    branch_req = 1'b1; branch_target = 32'h40;
    jump_req = 1'b1;   jump_target = 32'h80;
    settle();
    chk_out("br_kills_jmp", 1, 1, 1, 1, 2'b01, 32'h40);
    tick();

    branch_req = 1'b0;
    settle();
    chk_out("jump", 1, 1, 1, 0, 2'b11, 32'h80);
    tick();

    hazard_stall = 1'b1;
    settle();
    chk_out("jmp_over_hazard", 1, 1, 1, 0, 2'b11, 32'h80);
    tick();

    jump_req = 1'b0;
    settle();
    chk_out("hazard1", 0, 0, 0, 1, 2'b00, 32'h0);
    tick();
    settle();
    chk_out("hazard2", 0, 0, 0, 1, 2'b00, 32'h0);
    tick();

    idle_inputs();
    settle();
    chk_cnt("after_hazard", 3, 2);

    // jump captured under ext_stall, then overwritten by a branch
    ext_stall = 1'b1; jump_req = 1'b1; jump_target = 32'h100;
    settle();
    chk_out("ext_jump", 0, 0, 0, 0, 2'b00, 32'h0);
    chk_pend("ext_jump", 0);
    tick();
    jump_req = 1'b0; branch_req = 1'b1; branch_target = 32'h200;
    settle();
    chk_pend("hold1", 1);
    chk_out("hold1", 0, 0, 0, 0, 2'b00, 32'h0);
    tick();
    branch_req = 1'b0;
    settle();
    chk_pend("hold2", 1);
    tick();
    settle();
    chk_pend("hold3", 1);
    tick();
    ext_stall = 1'b0; jump_req = 1'b1; jump_target = 32'h300;
    settle();
    chk_pend("release", 1);
    chk_out("release", 1, 1, 1, 1, 2'b01, 32'h200);
    tick();
    jump_req = 1'b0;
    settle();
    chk_pend("back_run", 0);
    chk_out("back_run", 1, 1, 0, 0, 2'b00, 32'h0);
    chk_cnt("after_hold", 4, 6);
    tick();

    // held jump is not replaced by a later jump, released after 1 cycle
    ext_stall = 1'b1; jump_req = 1'b1; jump_target = 32'h88;
    tick();
    jump_target = 32'h99;
    settle();
    chk_pend("jhold", 1);
    tick();
    ext_stall = 1'b0; jump_req = 1'b0;
    settle();
    chk_out("jrelease", 1, 1, 1, 0, 2'b11, 32'h88);
    tick();

    // held branch, minimum latency
    ext_stall = 1'b1; branch_req = 1'b1; branch_target = 32'h44;
    tick();
    ext_stall = 1'b0; branch_req = 1'b0;
    settle();
    chk_out("brelease", 1, 1, 1, 1, 2'b01, 32'h44);
    tick();

    // Reset in HOLD drops the held jump
    ext_stall = 1'b1; jump_req = 1'b1; jump_target = 32'h100;
    tick();
    jump_req = 1'b0; Reset = 1'b1;
    settle();
    chk_pend("rst_in_hold", 1);
    chk_out("rst_in_hold", 1, 1, 0, 0, 2'b00, 32'h0);
    tick();
    Reset = 1'b0; ext_stall = 1'b0;
    settle();
    chk_pend("rst_dropped", 0);
    chk_out("rst_dropped", 1, 1, 0, 0, 2'b00, 32'h0);
    chk_cnt("rst_cleared", 0, 0);

    // 17 redirects wrap a 4-bit counter to 1
    branch_req = 1'b1; branch_target = 32'hC0;
    for (int unsigned i = 0; i < 17; i++) tick();
    branch_req = 1'b0;
    settle();
    chk_cnt("wrap", 1, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
